// File: rtl/rns_pkg.sv
// rns_pkg: shared definitions for the RNS datapath (forward and reverse
// converters).
//   - Default base exponent RNS_N and extra power-of-two exponent RNS_P.
//   - Derived widths: operand width, fold chunk count, residue widths.
//   - Moduli constants M1..M4 for {2^N-1, 2^N+1, 2^(2N)+1, 2^(2N+P)}.
//   - FSM state enum shared by the converters.
package rns_pkg;

  localparam int RNS_N = 2;
  localparam int RNS_P = 0;

  // Operand width and number of 4N-bit fold chunks at the default N/P.
  localparam int RNS_W = 6 * RNS_N + RNS_P;
  localparam int RNS_C = (RNS_W + 4 * RNS_N - 1) / (4 * RNS_N);

  // Residue widths; R2/R3 need one extra bit because their moduli are 2^k+1.
  localparam int R1_W = RNS_N;
  localparam int R2_W = RNS_N + 1;
  localparam int R3_W = 2 * RNS_N + 1;
  localparam int R4_W = 2 * RNS_N + RNS_P;

  localparam int M1 = (1 << RNS_N) - 1;
  localparam int M2 = (1 << RNS_N) + 1;
  localparam int M3 = (1 << (2 * RNS_N)) + 1;
  localparam int M4 = 1 << (2 * RNS_N + RNS_P);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FOLD   = 2'd1,
    REDUCE = 2'd2,
    HOLD   = 2'd3
  } rnsState_e;

endpackage

// File: rtl/rns_residue_reduce.sv
// rns_residue_reduce: combinational split of a value Y already reduced
// modulo 2^(4N)-1 into its three odd residues.
//   y  : 4N-bit input value
//   R1 : Y mod (2^N-1)    (N bits, never equals 2^N-1)
//   R2 : Y mod (2^N+1)    (N+1 bits, range 0..2^N)
//   R3 : Y mod (2^(2N)+1) (2N+1 bits, range 0..2^(2N))
module rns_residue_reduce
  import rns_pkg::*;
#(
  parameter int N = RNS_N
) (
  input  logic [4*N-1:0] y,
  output logic [N-1:0]   R1,
  output logic [N:0]     R2,
  output logic [2*N:0]   R3
);

  localparam logic [N+2:0]   M2C = (N+3)'((1 << N) + 1);
  localparam logic [2*N+1:0] M3C = (2*N+2)'((1 << (2 * N)) + 1);

  // R1: 2^N == 1 mod (2^N-1), so the N-bit chunks simply add. Two
  // end-around folds bring the 4-chunk sum back into N bits.
  logic [N+1:0] sum1;
  logic [N:0]   fold1;
  logic [N-1:0] fold2;

  always_comb begin
    sum1 = '0;
    for (int i = 0; i < 4; i++) begin
      sum1 = sum1 + (N+2)'(y[i*N +: N]);
    end
    fold1 = (N+1)'(sum1[N-1:0]) + (N+1)'(sum1[N+1:N]);
    fold2 = fold1[N-1:0] + N'(fold1[N]);
    // All ones is the second representation of zero.
    R1 = (fold2 == '1) ? '0 : fold2;
  end

  // R2: 2^N == -1 mod (2^N+1), so chunks alternate sign. Adding 2*M2
  // up front keeps the difference non-negative; it is then below 4*M2,
  // so at most three conditional subtractions finish the reduction.
  logic [N+2:0] posSum;
  logic [N+2:0] negSum;
  logic [N+2:0] diff2;

  always_comb begin
    posSum = (N+3)'(y[N-1:0]) + (N+3)'(y[3*N-1:2*N]) + (M2C << 1);
    negSum = (N+3)'(y[2*N-1:N]) + (N+3)'(y[4*N-1:3*N]);
    diff2  = posSum - negSum;
    for (int i = 0; i < 3; i++) begin
      if (diff2 >= M2C) diff2 = diff2 - M2C;
    end
    R2 = diff2[N:0];
  end

  // R3: 2^(2N) == -1 mod (2^(2N)+1): low half minus high half, with
  // the modulus added back when the two's-complement result is negative.
  logic [2*N+1:0] diff3;

  always_comb begin
    diff3 = {2'b00, y[2*N-1:0]} - {2'b00, y[4*N-1:2*N]};
    if (diff3[2*N+1]) diff3 = diff3 + M3C;
    R3 = diff3[2*N:0];
  end

endmodule

// File: rtl/binary_to_rns_converter.sv
// binary_to_rns_converter: multi-cycle forward converter from a binary
// operand X to residues for {2^N-1, 2^N+1, 2^(2N)+1, 2^(2N+P)}.
// X is first folded modulo 2^(4N)-1 one 4N-bit chunk per cycle with
// end-around carry, then split into the three odd residues in one cycle.
//   clk, rst            : clock (rising edge), async active-high reset
//   in_valid/in_ready   : operand handshake, in_x is the operand
//   out_valid/out_ready : result handshake, R1..R4 are the residues
//   dbgState            : current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer keeps its data stable while valid=1 and ready=0.
// in_ready is 1 only in IDLE; out_valid and R1..R4 stay frozen in HOLD until
// out_ready=1. A new operand is only taken in IDLE, so there is always at
// least one idle cycle between results.
module binary_to_rns_converter
  import rns_pkg::*;
#(
  parameter int N = RNS_N,
  parameter int P = RNS_P
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6*N+P-1:0] in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     R1,
  output logic [N:0]       R2,
  output logic [2*N:0]     R3,
  output logic [2*N+P-1:0] R4,
  output rnsState_e        dbgState
);

  localparam int W   = 6 * N + P;
  localparam int FW  = 4 * N;
  localparam int C   = (W + FW - 1) / FW;
  localparam int CIW = (C > 1) ? $clog2(C) : 1;
  localparam int R4W = 2 * N + P;

  rnsState_e      state;
  logic [C*FW-1:0] xReg;      // operand, zero-extended to whole chunks
  logic [FW-1:0]   acc;
  logic [CIW-1:0]  chunkIdx;

  logic [FW-1:0]   chunk;
  logic [FW:0]     foldSum;
  logic [FW-1:0]   foldNext;
  logic [FW-1:0]   yCanon;
  logic [N-1:0]    redR1;
  logic [N:0]      redR2;
  logic [2*N:0]    redR3;

  always_comb begin
    chunk = '0;
    for (int i = 0; i < C; i++) begin
      if (chunkIdx == CIW'(i)) chunk = xReg[i*FW +: FW];
    end
  end

  // acc and chunk are both <= 2^(4N)-1, so when the carry is set the low
  // word is at most 2^(4N)-2 and wrapping the carry cannot overflow again.
  assign foldSum  = {1'b0, acc} + {1'b0, chunk};
  assign foldNext = foldSum[FW-1:0] + FW'(foldSum[FW]);

  // All ones and zero are the same value modulo 2^(4N)-1.
  assign yCanon = (acc == '1) ? '0 : acc;

  rns_residue_reduce #(.N(N)) uReduce (
    .y  (yCanon),
    .R1 (redR1),
    .R2 (redR2),
    .R3 (redR3)
  );

  assign dbgState = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      xReg      <= '0;
      acc       <= '0;
      chunkIdx  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      R1        <= '0;
      R2        <= '0;
      R3        <= '0;
      R4        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xReg     <= (C*FW)'(in_x);
            acc      <= '0;
            chunkIdx <= '0;
            // The power-of-two residue is just the low bits of X.
            R4       <= in_x[R4W-1:0];
            in_ready <= 1'b0;
            state    <= FOLD;
          end
        end
        FOLD: begin
          acc      <= foldNext;
          chunkIdx <= chunkIdx + CIW'(1);
          if (chunkIdx == CIW'(C - 1)) state <= REDUCE;
        end
        REDUCE: begin
          R1        <= redR1;
          R2        <= redR2;
          R3        <= redR3;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_rns_converter.sv
// tb_binary_to_rns_converter: directed bench for binary_to_rns_converter at
// N=2, P=0 (moduli 3, 5, 17, 16; 12-bit operand, 2 fold chunks).
module tb_binary_to_rns_converter;
  import rns_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [11:0] in_x;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] R1;
  logic [2:0] R2;
  logic [4:0] R3;
  logic [3:0] R4;
  rnsState_e  dbgState;

  int errors = 0;
  int checks = 0;

  binary_to_rns_converter #(.N(2), .P(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R1        (R1),
    .R2        (R2),
    .R3        (R3),
    .R4        (R4),
    .dbgState  (dbgState)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  // All driver tasks start and end 1 time unit after a rising edge.

  // Present one operand for a single edge; reports in_ready seen at that edge.
  task automatic drive_operand(input logic [11:0] x, output logic readySeen);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    readySeen = in_ready;
    in_valid  = 1'b1;
    in_x      = x;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    // Scramble the bus: the registered operand must be unaffected.
    in_x      = 12'($urandom_range(0, 4095));
  endtask

  // Count edges after the accept edge until out_valid rises (bounded).
  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!out_valid && cycles < 20);
  endtask

  task automatic release_output();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_x = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b expected 0", out_valid); end
    checks++; if (R1 !== 2'd0) begin errors++; $display("FAIL reset_R1 got %0d expected 0", R1); end
    checks++; if (R2 !== 3'd0) begin errors++; $display("FAIL reset_R2 got %0d expected 0", R2); end
    checks++; if (R3 !== 5'd0) begin errors++; $display("FAIL reset_R3 got %0d expected 0", R3); end
    checks++; if (R4 !== 4'd0) begin errors++; $display("FAIL reset_R4 got %0d expected 0", R4); end
    checks++; if (dbgState !== IDLE) begin errors++; $display("FAIL reset_state got %0d expected %0d", dbgState, IDLE); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Directed vectors: nominal values, the all-ones fold, and range edges.
  task automatic test_vectors();
    logic [11:0] vx[6] = '{12'd100, 12'd78, 12'd255, 12'd0, 12'd4079, 12'd4095};
    logic [1:0]  e1[6] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0};
    logic [2:0]  e2[6] = '{3'd0, 3'd3, 3'd0, 3'd0, 3'd4, 3'd0};
    logic [4:0]  e3[6] = '{5'd15, 5'd10, 5'd0, 5'd0, 5'd16, 5'd15};
    logic [3:0]  e4[6] = '{4'd4, 4'd14, 4'd15, 4'd0, 4'd15, 4'd15};
    logic        rdy;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      drive_operand(vx[i], rdy);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL vec%0d_accept in_ready got %0b expected 1", i, rdy); end
      wait_valid(lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL vec%0d_latency got %0d cycles expected 3", i, lat); end
      checks++; if (R1 !== e1[i]) begin errors++; $display("FAIL vec%0d_R1 x=%0d got %0d expected %0d", i, vx[i], R1, e1[i]); end
      checks++; if (R2 !== e2[i]) begin errors++; $display("FAIL vec%0d_R2 x=%0d got %0d expected %0d", i, vx[i], R2, e2[i]); end
      checks++; if (R3 !== e3[i]) begin errors++; $display("FAIL vec%0d_R3 x=%0d got %0d expected %0d", i, vx[i], R3, e3[i]); end
      checks++; if (R4 !== e4[i]) begin errors++; $display("FAIL vec%0d_R4 x=%0d got %0d expected %0d", i, vx[i], R4, e4[i]); end
      release_output();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_drop_valid got %0b expected 0", i, out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL vec%0d_back_ready got %0b expected 1", i, in_ready); end
    end
  endtask

  // Results held under backpressure; in_valid while busy is ignored.
  task automatic test_backpressure();
    logic rdy;
    int   lat;
    drive_operand(12'd100, rdy);
    wait_valid(lat);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid got %0b expected 1", out_valid); end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_x = 12'd7;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc%0d got %0b expected 1", c, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got %0b expected 0", c, in_ready); end
      checks++; if ({R1, R2, R3, R4} !== {2'd1, 3'd0, 5'd15, 4'd4}) begin
        errors++; $display("FAIL bp_hold_residues cyc%0d got %0d/%0d/%0d/%0d expected 1/0/15/4", c, R1, R2, R3, R4);
      end
    end
    in_valid = 1'b0;
    release_output();
    repeat (4) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_phantom got %0b expected 0", out_valid); end
    checks++; if (dbgState !== IDLE) begin errors++; $display("FAIL bp_idle_state got %0d expected %0d", dbgState, IDLE); end
    // The second operand is taken only now, from IDLE.
    drive_operand(12'd7, rdy);
    wait_valid(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL bp_second_latency got %0d expected 3", lat); end
    checks++; if ({R1, R2, R3, R4} !== {2'd1, 3'd2, 5'd7, 4'd7}) begin
      errors++; $display("FAIL bp_second_residues got %0d/%0d/%0d/%0d expected 1/2/7/7", R1, R2, R3, R4);
    end
    release_output();
  endtask

  // Asynchronous reset during FOLD discards the operand immediately.
  task automatic test_reset_mid_fold();
    logic rdy;
    int   lat;
    drive_operand(12'd78, rdy);
    checks++; if (dbgState !== FOLD) begin errors++; $display("FAIL rmf_in_fold got %0d expected %0d", dbgState, FOLD); end
    #3 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmf_out_valid got %0b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmf_in_ready got %0b expected 1", in_ready); end
    checks++; if ({R1, R2, R3, R4} !== 14'd0) begin
      errors++; $display("FAIL rmf_residues got %0d/%0d/%0d/%0d expected 0/0/0/0", R1, R2, R3, R4);
    end
    checks++; if (dbgState !== IDLE) begin errors++; $display("FAIL rmf_state got %0d expected %0d", dbgState, IDLE); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    drive_operand(12'd4079, rdy);
    wait_valid(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rmf_after_latency got %0d expected 3", lat); end
    checks++; if ({R1, R2, R3, R4} !== {2'd2, 3'd4, 5'd16, 4'd15}) begin
      errors++; $display("FAIL rmf_after_residues got %0d/%0d/%0d/%0d expected 2/4/16/15", R1, R2, R3, R4);
    end
    release_output();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_fold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
